// File: rtl/ray_inv_dir.sv
// Per-axis reciprocal of a ray direction (Q16.16 in, Q18.18 out).
// Three restoring dividers run in parallel, one quotient bit per cycle.
package ray_inv_dir_pkg;
    typedef logic [2:0][31:0] vec3_t;
    typedef logic [2:0][35:0] vec3_18_18_t;
endpackage

module ray_inv_dir
    import ray_inv_dir_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  vec3_t       ray_orig_in,
    input  vec3_t       ray_dir,
    output logic        out_valid,
    input  logic        out_ready,
    output vec3_t       ray_orig,
    output vec3_18_18_t inv_ray_dir,
    output logic [2:0]  div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [5:0]             cnt;
    logic [2:0][31:0]       mag;
    logic [2:0]             neg;
    logic [2:0][31:0]       rem;
    logic [2:0][34:0]       quo;
    logic [2:0][32:0]       rs;
    logic [2:0][32:0]       diff;
    logic [2:0][31:0]       rem_nxt;
    logic [2:0][34:0]       quo_nxt;
    logic [2:0][35:0]       res;
    logic                   accept;
    logic                   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nxt = DIV;
            end
            DIV: begin
                if (cnt == 6'd34) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == DIV) && (cnt == 6'd34);

    // The 2^34 dividend has a single set bit, consumed on the first step.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rs[i]   = {rem[i], cnt == 6'd0};
            diff[i] = rs[i] - {1'b0, mag[i]};
            if (rs[i] >= {1'b0, mag[i]}) begin
                rem_nxt[i] = diff[i][31:0];
                quo_nxt[i] = {quo[i][33:0], 1'b1};
            end else begin
                rem_nxt[i] = rs[i][31:0];
                quo_nxt[i] = {quo[i][33:0], 1'b0};
            end
            if (div_by_zero[i])
                res[i] = 36'd0;
            else if (neg[i])
                res[i] = 36'd0 - {1'b0, quo_nxt[i]};
            else
                res[i] = {1'b0, quo_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            mag         <= '0;
            neg         <= '0;
            rem         <= '0;
            quo         <= '0;
            ray_orig    <= '0;
            inv_ray_dir <= '0;
            div_by_zero <= '0;
        end else if (accept) begin
            cnt      <= '0;
            ray_orig <= ray_orig_in;
            rem      <= '0;
            quo      <= '0;
            for (int i = 0; i < 3; i++) begin
                mag[i]         <= ray_dir[i][31] ? (~ray_dir[i] + 32'd1)
                                                 : ray_dir[i];
                neg[i]         <= ray_dir[i][31];
                div_by_zero[i] <= (ray_dir[i] == 32'd0);
            end
        end else if (state == DIV) begin
            cnt <= cnt + 6'd1;
            for (int i = 0; i < 3; i++) begin
                if (!div_by_zero[i]) begin
                    rem[i] <= rem_nxt[i];
                    quo[i] <= quo_nxt[i];
                end
            end
            if (last) inv_ray_dir <= res;
        end
    end

endmodule

// File: tb/tb_ray_inv_dir.sv
// Directed vector bench for ray_inv_dir.
// Covers latency, sign/zero handling, backpressure hold and mid-divide reset.
module tb_ray_inv_dir;
    import ray_inv_dir_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    vec3_t       ray_orig_in = '0;
    vec3_t       ray_dir = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    vec3_t       ray_orig;
    vec3_18_18_t inv_ray_dir;
    logic [2:0]  div_by_zero;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        vec3_t       orig;
        vec3_t       dir;
        vec3_18_18_t inv;
        logic [2:0]  dbz;
    } vec_t;

    vec_t tv[5];

    ray_inv_dir dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ray_orig_in (ray_orig_in),
        .ray_dir     (ray_dir),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ray_orig    (ray_orig),
        .inv_ray_dir (inv_ray_dir),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_ray(input vec_t v);
        @(negedge clk);
        check("in_ready_before", 64'(in_ready), 64'd1);
        ray_orig_in = v.orig;
        ray_dir     = v.dir;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        ray_orig_in = '1;
        ray_dir     = '1;
    endtask

    task automatic check_out(input vec_t v, input string tag);
        for (int a = 0; a < 3; a++) begin
            check($sformatf("%s_inv%0d", tag, a),
                  64'(inv_ray_dir[a]), 64'(v.inv[a]));
            check($sformatf("%s_orig%0d", tag, a),
                  64'(ray_orig[a]), 64'(v.orig[a]));
        end
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(v.dbz));
    endtask

    // Handshake edge counts as edge 1; out_valid must rise on edge 36.
    task automatic run_ray(input vec_t v, input string tag);
        start_ray(v);
        for (int k = 2; k <= 36; k++) begin
            @(posedge clk);
            #1;
            if (k == 35) check({tag, "_early"}, 64'(out_valid), 64'd0);
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_ready_busy"}, 64'(in_ready), 64'd0);
        check_out(v, tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        tv[0].orig = '{32'h0, 32'h0, 32'h0};
        tv[0].dir  = '{32'h0, 32'h0, 32'h0001_0000};
        tv[0].inv  = '{36'h0, 36'h0, 36'h0_0004_0000};
        tv[0].dbz  = 3'b110;

        tv[1].orig = '{32'h3, 32'h2, 32'h1};
        tv[1].dir  = '{32'h0, 32'h0000_8000, 32'hFFFE_0000};
        tv[1].inv  = '{36'h0, 36'h0_0008_0000, 36'hF_FFFE_0000};
        tv[1].dbz  = 3'b100;

        tv[2].orig = '{32'hCAFE_BABE, 32'h8000_0000, 32'h7FFF_FFFF};
        tv[2].dir  = '{32'h0003_0000, 32'h8000_0000, 32'h0000_0001};
        tv[2].inv  = '{36'h0_0001_5555, 36'hF_FFFF_FFF8, 36'h4_0000_0000};
        tv[2].dbz  = 3'b000;

        tv[3].orig = '{32'h0, 32'hDEAD_BEEF, 32'h0};
        tv[3].dir  = '{32'h0, 32'h0, 32'h0};
        tv[3].inv  = '{36'h0, 36'h0, 36'h0};
        tv[3].dbz  = 3'b111;

        tv[4].orig = '{32'h7, 32'hFFFF_FFFF, 32'h1234_5678};
        tv[4].dir  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000};
        tv[4].inv  = '{36'h0_0000_0008, 36'hC_0000_0000, 36'h0_0002_0000};
        tv[4].dbz  = 3'b000;

        #2;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_inv", 64'(inv_ray_dir[0]), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        for (int t = 0; t < 5; t++)
            run_ray(tv[t], $sformatf("v%0d", t));

        // Backpressure: ten stalled cycles, with a stray ray offered.
        start_ray(tv[2]);
        for (int k = 2; k <= 36; k++) @(posedge clk);
        #1;
        check("hold_valid", 64'(out_valid), 64'd1);
        ray_orig_in = tv[0].orig;
        ray_dir     = tv[0].dir;
        in_valid    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 64'(in_ready), 64'd0);
            check("hold_vld", 64'(out_valid), 64'd1);
            check_out(tv[2], "hold");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_rel_valid", 64'(out_valid), 64'd0);
        check("hold_rel_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a divide, at counter 17.
        start_ray(tv[4]);
        for (int k = 0; k < 17; k++) @(posedge clk);
        #1;
        check("mid_valid_pre", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_ready", 64'(in_ready), 64'd0);
        check("mid_orig", 64'(ray_orig[0]), 64'd0);
        check("mid_inv", 64'(inv_ray_dir[2]), 64'd0);
        check("mid_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_ray(tv[1], "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ray_inv_dir.md
RAY_INV_DIR -- requirements
Module: ray_inv_dir

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream ray present on ray_orig_in/ray_dir.
REQ-004 SHALL have port in_ready, output, 1, block can accept a ray (high only in IDLE).
REQ-005 SHALL have port ray_orig_in, input, vec3, ray origin (Q16.16 signed per axis), passed through unchanged.
REQ-006 SHALL have port ray_dir, input, vec3, ray direction (Q16.16 signed per axis).
REQ-007 SHALL have port out_valid, output, 1, result valid for ray_bbox_intersect.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-009 SHALL have port ray_orig, output, vec3, registered copy of accepted origin.
REQ-010 SHALL have port inv_ray_dir, output, vec3_18_18, per-axis reciprocal (Q18.18 signed, 36 bits).
REQ-011 SHALL have port div_by_zero, output, 3, bit0=x, bit1=y, bit2=z; set when that ray_dir component is zero.

Function
REQ-012 SHALL implement FSM states IDLE, DIV, DONE; reset state IDLE.
REQ-013 SHALL in IDLE, on in_valid && in_ready at a clock edge, capture ray_orig_in, |ray_dir| per axis, sign per axis and zero flags, clear 6-bit counter, go to DIV.
REQ-014 SHALL in DIV, run three parallel restoring dividers computing 2^34 / |d| (35-bit dividend), producing one quotient bit per cycle, MSB first.
REQ-015 SHALL increment the counter each DIV cycle and go to DONE on the edge where counter==34 (35 DIV cycles total).
REQ-016 SHALL assert out_valid only in DONE; latency from input handshake edge to out_valid high is 36 edges.
REQ-017 SHALL hold ray_orig, inv_ray_dir and div_by_zero stable while out_valid && !out_ready.
REQ-018 SHALL, on out_valid && out_ready, return to IDLE; no new ray is accepted in the same cycle.
REQ-019 SHALL take |d| as a 32-bit unsigned magnitude (-2^31 maps to 2^31 without overflow).
REQ-020 SHALL truncate the quotient toward zero, then negate it in 36-bit two's complement when d<0.
REQ-021 SHALL output inv_ray_dir component = 0 and div_by_zero bit = 1 for d==0; the divider for that axis is gated and latency is unchanged.
REQ-022 SHALL never saturate (max magnitude 2^34 at |d|=1 fits in signed 36 bits).
REQ-023 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-DIV, asynchronously force IDLE, abort any division, and clear out_valid, ray_orig, inv_ray_dir, div_by_zero and counter to 0.
REQ-025 SHALL drive in_ready=0 while rst_n is low, and in_ready=1 on the first cycle after release.

Verification
REQ-026 SHALL pass: dir=(0x0001_0000,0,0), orig=0 -> after 36 edges, inv x=0x0_0004_0000, y=z=0, div_by_zero=3'b110, ray_orig=0.
REQ-027 SHALL pass: dir=(-2.0,0.5,0) -> inv x=-(1<<17), y=(1<<19), z=0, div_by_zero=3'b100.
REQ-028 SHALL pass: dir=(1 LSB, 0x8000_0000, 0x0003_0000) -> inv x=2^34, y=-8, z=0x0_0001_5555 (truncated), div_by_zero=3'b000.
REQ-029 SHALL pass: dir=(0,0,0) -> out_valid after 36 edges, inv all 0, div_by_zero=3'b111.
REQ-030 SHALL pass: out_ready held low for 10 cycles in DONE -> outputs bit-stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 SHALL pass: rst_n pulsed low at DIV counter=17 -> out_valid=0 and outputs zero immediately; the next ray completes with full 36-edge latency and correct result.
